// File: rtl/jellyvl_etherneco_rtt_monitor_if.sv
// Returned-frame byte stream from the outer ring receive path into the RTT monitor.
interface jellyvl_etherneco_rtt_monitor_if;
  logic       first;
  logic       last;
  logic       valid;
  logic [7:0] data;
  logic       ready;

  modport master (output first, last, valid, data, input  ready);
  modport slave  (input  first, last, valid, data, output ready);
endinterface

// File: rtl/jellyvl_etherneco_rtt_monitor.sv
// Ring round-trip-time monitor: timestamps a frame launch and its first returned beat.
// Optional min/max/count statistics are built when JELLYVL_ETHERNECO_RTT_STATS_EN is defined.
module jellyvl_etherneco_rtt_monitor #(
  parameter int unsigned TIMER_WIDTH    = 64,
  parameter int unsigned EXPECT_LENGTH  = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                          reset,
  input  logic                          clk,
  input  logic [TIMER_WIDTH-1:0]        current_time,
  input  logic                          start,
  jellyvl_etherneco_rtt_monitor_if.slave s_rx,
  output logic                          busy,
  output logic [TIMER_WIDTH-1:0]        m_rtt,
  output logic                          m_rtt_valid,
  output logic                          m_error,
  output logic                          m_timeout,
  output logic                          m_overrun,
  output logic [TIMER_WIDTH-1:0]        m_rtt_min,
  output logic [TIMER_WIDTH-1:0]        m_rtt_max,
  output logic [31:0]                   m_frame_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RECV = 2'd2;

  localparam int unsigned       CYC_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned       CNT_W      = $clog2(EXPECT_LENGTH + 2);
  localparam logic [CYC_W-1:0]  CYC_LAST   = CYC_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_EXPECT = CNT_W'(EXPECT_LENGTH);
  localparam logic [CNT_W-1:0]  CNT_SAT    = CNT_W'(EXPECT_LENGTH + 1);

  logic [1:0]             state_q, state_d;
  logic [7:0]             seq_q, seq_d;
  logic [TIMER_WIDTH-1:0] t0_q, t0_d;
  logic [TIMER_WIDTH-1:0] t1_q, t1_d;
  logic [CYC_W-1:0]       cyc_q, cyc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   seq_ok_q, seq_ok_d;
  logic                   ready_q;
  logic [TIMER_WIDTH-1:0] rtt_q, rtt_d;
  logic                   rtt_valid_q, rtt_valid_d;
  logic                   error_q, error_d;
  logic                   timeout_q, timeout_d;
  logic                   overrun_q, overrun_d;

  logic                   beat;
  logic [TIMER_WIDTH-1:0] t1_eff;
  logic [CNT_W-1:0]       cnt_eff;
  logic                   seq_ok_eff;

  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    t0_d        = t0_q;
    t1_d        = t1_q;
    cyc_d       = cyc_q;
    cnt_d       = cnt_q;
    seq_ok_d    = seq_ok_q;
    rtt_d       = rtt_q;
    rtt_valid_d = 1'b0;
    error_d     = 1'b0;
    timeout_d   = 1'b0;
    overrun_d   = 1'b0;

    beat = s_rx.valid & ready_q;
    // A first beat (re)starts capture, so a first&last single beat is evaluated with its own values.
    t1_eff     = s_rx.first ? current_time : t1_q;
    cnt_eff    = s_rx.first ? CNT_W'(1)
               : (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
    seq_ok_eff = s_rx.first ? (s_rx.data == seq_q) : seq_ok_q;

    if (start) begin
      overrun_d = (state_q != ST_IDLE);
      state_d   = ST_WAIT;
      seq_d     = seq_q + 8'd1;
      t0_d      = current_time;
      cyc_d     = '0;
    end else if (state_q != ST_IDLE) begin
      cyc_d = cyc_q + CYC_W'(1);
      if (cyc_q == CYC_LAST) begin
        timeout_d = 1'b1;
        state_d   = ST_IDLE;
      end else if (beat && (state_q == ST_RECV || s_rx.first)) begin
        state_d  = ST_RECV;
        t1_d     = t1_eff;
        cnt_d    = cnt_eff;
        seq_ok_d = seq_ok_eff;
        if (s_rx.last) begin
          state_d = ST_IDLE;
          if (cnt_eff == CNT_EXPECT && seq_ok_eff) begin
            rtt_valid_d = 1'b1;
            rtt_d       = t1_eff - t0_q;
          end else begin
            error_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      seq_q       <= '0;
      t0_q        <= '0;
      t1_q        <= '0;
      cyc_q       <= '0;
      cnt_q       <= '0;
      seq_ok_q    <= 1'b0;
      ready_q     <= 1'b0;
      rtt_q       <= '0;
      rtt_valid_q <= 1'b0;
      error_q     <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      t0_q        <= t0_d;
      t1_q        <= t1_d;
      cyc_q       <= cyc_d;
      cnt_q       <= cnt_d;
      seq_ok_q    <= seq_ok_d;
      ready_q     <= 1'b1;
      rtt_q       <= rtt_d;
      rtt_valid_q <= rtt_valid_d;
      error_q     <= error_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
    end
  end

  assign s_rx.ready  = ready_q;
  assign busy        = (state_q != ST_IDLE);
  assign m_rtt       = rtt_q;
  assign m_rtt_valid = rtt_valid_q;
  assign m_error     = error_q;
  assign m_timeout   = timeout_q;
  assign m_overrun   = overrun_q;

`ifdef JELLYVL_ETHERNECO_RTT_STATS_EN
  logic [TIMER_WIDTH-1:0] rtt_min_q, rtt_min_d;
  logic [TIMER_WIDTH-1:0] rtt_max_q, rtt_max_d;
  logic [31:0]            frame_count_q, frame_count_d;

  // Statistics move on the same edge as m_rtt so they are current while m_rtt_valid is high.
  always_comb begin
    rtt_min_d     = rtt_min_q;
    rtt_max_d     = rtt_max_q;
    frame_count_d = frame_count_q;
    if (rtt_valid_d) begin
      if (rtt_d < rtt_min_q) rtt_min_d = rtt_d;
      if (rtt_d > rtt_max_q) rtt_max_d = rtt_d;
      if (frame_count_q != '1) frame_count_d = frame_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rtt_min_q     <= '1;
      rtt_max_q     <= '0;
      frame_count_q <= '0;
    end else begin
      rtt_min_q     <= rtt_min_d;
      rtt_max_q     <= rtt_max_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign m_rtt_min     = rtt_min_q;
  assign m_rtt_max     = rtt_max_q;
  assign m_frame_count = frame_count_q;
`else
  assign m_rtt_min     = '0;
  assign m_rtt_max     = '0;
  assign m_frame_count = '0;
`endif

endmodule

// File: tb/tb_jellyvl_etherneco_rtt_monitor.sv
// Directed scoreboard bench for jellyvl_etherneco_rtt_monitor (TIMEOUT_CYCLES=100).
module tb_jellyvl_etherneco_rtt_monitor;

  localparam logic [3:0] K_VALID = 4'b0001;
  localparam logic [3:0] K_ERR   = 4'b0010;
  localparam logic [3:0] K_TO    = 4'b0100;
  localparam logic [3:0] K_OVR   = 4'b1000;

  typedef struct {
    logic [3:0]  mask;
    logic [63:0] rtt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] current_time = '0;
  logic        start = 1'b0;
  logic        busy;
  logic [63:0] m_rtt, m_rtt_min, m_rtt_max;
  logic        m_rtt_valid, m_error, m_timeout, m_overrun;
  logic [31:0] m_frame_count;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [63:0] exp_rtt = '0;
  logic [63:0] mdl_min = '1;
  logic [63:0] mdl_max = '0;
  int          mdl_cnt = 0;

  jellyvl_etherneco_rtt_monitor_if rx ();

  jellyvl_etherneco_rtt_monitor #(
    .TIMER_WIDTH   (64),
    .EXPECT_LENGTH (32),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .reset        (reset),
    .clk          (clk),
    .current_time (current_time),
    .start        (start),
    .s_rx         (rx),
    .busy         (busy),
    .m_rtt        (m_rtt),
    .m_rtt_valid  (m_rtt_valid),
    .m_error      (m_error),
    .m_timeout    (m_timeout),
    .m_overrun    (m_overrun),
    .m_rtt_min    (m_rtt_min),
    .m_rtt_max    (m_rtt_max),
    .m_frame_count(m_frame_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input logic [3:0] kind, input logic [63:0] rtt);
    exp_t e;
    if (kind == K_VALID) begin
      exp_rtt = rtt;
      if (rtt < mdl_min) mdl_min = rtt;
      if (rtt > mdl_max) mdl_max = rtt;
      mdl_cnt++;
    end
    e.mask = kind;
    e.rtt  = exp_rtt;
    sb.push_back(e);
  endtask

  task automatic do_start(input logic [63:0] t0);
    current_time = t0;
    start        = 1'b1;
    step();
    start        = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Sends len beats; the expectation (if any) is pushed just before the last beat is driven.
  task automatic send_frame(input int len, input logic [7:0] b0, input logic [63:0] t1,
                            input bit with_last, input logic [3:0] kind, input logic [63:0] rtt);
    for (int i = 0; i < len; i++) begin
      if (i == len - 1 && with_last && kind != 4'b0) expect_evt(kind, rtt);
      rx.valid = 1'b1;
      rx.first = (i == 0);
      rx.last  = with_last && (i == len - 1);
      rx.data  = (i == 0) ? b0 : 8'(i + 8'h40);
      if (i == 0) current_time = t1;
      else        current_time = current_time + 64'd8;
      step();
    end
    rx.valid = 1'b0;
    rx.first = 1'b0;
    rx.last  = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    step();
    step();
    exp_rtt = '0;
    mdl_min = '1;
    mdl_max = '0;
    mdl_cnt = 0;
    chk("reset_ready", 64'(rx.ready), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_rtt", m_rtt, 64'd0);
    chk("reset_pulses", 64'({m_overrun, m_timeout, m_error, m_rtt_valid}), 64'd0);
`ifdef JELLYVL_ETHERNECO_RTT_STATS_EN
    chk("reset_min", m_rtt_min, '1);
`else
    chk("reset_min", m_rtt_min, 64'd0);
`endif
    chk("reset_max", m_rtt_max, 64'd0);
    chk("reset_count", 64'(m_frame_count), 64'd0);
    reset = 1'b1;
    step();
    chk("ready_after_release", 64'(rx.ready), 64'd1);
  endtask

  always @(negedge clk) begin : monitor
    logic [3:0] mask;
    exp_t       e;
    mask = {m_overrun, m_timeout, m_error, m_rtt_valid};
    if (mask != 4'b0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_pulse: observed=%b expected=none", mask);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", 64'(mask), 64'(e.mask));
        chk("pulse_rtt", m_rtt, e.rtt);
      end
    end
  end

  initial begin : stim
    int n;
    bit found;
    rx.valid = 1'b0;
    rx.first = 1'b0;
    rx.last  = 1'b0;
    rx.data  = '0;

    apply_reset();

    // Frame in IDLE is ignored; seq is 0 so only the state gating rejects it.
    send_frame(32, 8'h00, 64'd500, 1'b1, 4'b0, 64'd0);
    chk("idle_frame_busy", 64'(busy), 64'd0);

    // Good frame: t0=1000, t1=1640.
    do_start(64'd1000);
    chk("busy_after_start", 64'(busy), 64'd1);
    idle(3);
    send_frame(32, 8'h01, 64'd1640, 1'b1, K_VALID, 64'd640);
    chk("busy_falls", 64'(busy), 64'd0);
    chk("rtt_640", m_rtt, 64'd640);

    // Short frame, wrong seq, single first&last beat.
    do_start(64'd2000);
    send_frame(31, 8'h02, 64'd2100, 1'b1, K_ERR, 64'd0);
    do_start(64'd3000);
    send_frame(32, 8'h55, 64'd3100, 1'b1, K_ERR, 64'd0);
    do_start(64'd4000);
    send_frame(1, 8'h04, 64'd4100, 1'b1, K_ERR, 64'd0);
    idle(1);
    chk("rtt_unchanged", m_rtt, 64'd640);

    // Timeout with no frame.
    expect_evt(K_TO, 64'd0);
    do_start(64'd5000);
    n = 0;
    found = 1'b0;
    for (int c = 1; c <= 200 && !found; c++) begin
      step();
      if (c == 99) chk("busy_before_timeout", 64'(busy), 64'd1);
      if (m_timeout) begin
        found = 1'b1;
        n = c;
      end
    end
    chk("timeout_latency", 64'(n), 64'd100);
    chk("idle_after_timeout", 64'(busy), 64'd0);

    // Timer wrap-around.
    do_start(64'hFFFF_FFFF_FFFF_FFF0);
    send_frame(32, 8'h06, 64'd16, 1'b1, K_VALID, 64'd32);

    // Last beat one cycle before timeout is accepted; at the timeout cycle it is not.
    do_start(64'd10000);
    idle(67);
    send_frame(32, 8'h07, 64'd10500, 1'b1, K_VALID, 64'd500);
    do_start(64'd20000);
    idle(68);
    send_frame(32, 8'h08, 64'd20500, 1'b1, K_TO, 64'd0);
    idle(1);
    chk("busy_after_late_last", 64'(busy), 64'd0);

    // Reset mid-frame: no pulse, later first beat ignored.
    do_start(64'd30000);
    send_frame(10, 8'h09, 64'd30100, 1'b0, 4'b0, 64'd0);
    apply_reset();
    send_frame(32, 8'h00, 64'd30500, 1'b1, 4'b0, 64'd0);
    chk("busy_after_reset_frame", 64'(busy), 64'd0);

    // Overrun, then the re-armed frame carries seq 0x02.
    do_start(64'd900);
    send_frame(10, 8'h01, 64'd950, 1'b0, 4'b0, 64'd0);
    expect_evt(K_OVR, 64'd0);
    do_start(64'd1000);
    chk("busy_after_overrun", 64'(busy), 64'd1);
    send_frame(32, 8'h02, 64'd1640, 1'b1, K_VALID, 64'd640);
    do_start(64'd2000);
    send_frame(32, 8'h03, 64'd2500, 1'b1, K_VALID, 64'd500);
    do_start(64'd3000);
    send_frame(32, 8'h04, 64'd3700, 1'b1, K_VALID, 64'd700);
    idle(2);
    chk("rtt_last", m_rtt, 64'd700);

`ifdef JELLYVL_ETHERNECO_RTT_STATS_EN
    chk("stats_min", m_rtt_min, mdl_min);
    chk("stats_max", m_rtt_max, mdl_max);
    chk("stats_count", 64'(m_frame_count), 64'(mdl_cnt));
`else
    chk("stats_min", m_rtt_min, 64'd0);
    chk("stats_max", m_rtt_max, 64'd0);
    chk("stats_count", 64'(m_frame_count), 64'd0);
`endif

    idle(3);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
